// File: rtl/uart_rx_if.sv
// FIFO-side bundle of the UART receiver: received byte, write strobe, full flag and status pulses.
interface uart_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             wr;
    logic             full;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;

    modport master (
        output data, wr, busy, frame_err, overrun, parity_err,
        input  full
    );

    modport slave (
        input  data, wr, busy, frame_err, overrun, parity_err,
        output full
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver feeding the echo FIFO; LSB-first, one stop bit, single-cycle status pulses.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int DIV_W        = $clog2(CLKS_PER_BIT);
    localparam int CNT_W        = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $fatal(1, "uart_rx: CLKS_PER_BIT must be >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $fatal(1, "uart_rx: SYNC_STAGES must be >= 2");
    end

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5
    } state_e;

    function automatic logic parity_ok(input logic [WIDTH-1:0] d, input logic p);
        parity_ok = (p == ((^d) ^ (PARITY_ODD != 0)));
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;

    state_e           state_r,  state_nxt_s;
    logic [DIV_W-1:0] div_r,    div_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic [WIDTH-1:0] shift_r,  shift_nxt_s;
    logic [WIDTH-1:0] data_r,   data_nxt_s;
    logic             wr_r,     wr_nxt_s;
    logic             ferr_r,   ferr_nxt_s;
    logic             ovr_r,    ovr_nxt_s;
    logic             perr_r,   perr_nxt_s;
    logic             busy_r,   busy_nxt_s;
    logic             par_r,    par_nxt_s;

    // rx synchroniser chain; only the last stage feeds decisions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs_s = sync_r[SYNC_STAGES-1];

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT_IDLE;
            div_r   <= DIV_ZERO;
            cnt_r   <= CNT_ZERO;
            shift_r <= {WIDTH{1'b0}};
            data_r  <= {WIDTH{1'b0}};
            wr_r    <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
            perr_r  <= 1'b0;
            busy_r  <= 1'b0;
            par_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            div_r   <= div_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shift_r <= shift_nxt_s;
            data_r  <= data_nxt_s;
            wr_r    <= wr_nxt_s;
            ferr_r  <= ferr_nxt_s;
            ovr_r   <= ovr_nxt_s;
            perr_r  <= perr_nxt_s;
            busy_r  <= busy_nxt_s;
            par_r   <= par_nxt_s;
        end
    end

    // next-state, bit sampling and pulse generation
    always_comb begin
        state_nxt_s = state_r;
        div_nxt_s   = div_r;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
        data_nxt_s  = data_r;
        wr_nxt_s    = 1'b0;
        ferr_nxt_s  = 1'b0;
        ovr_nxt_s   = 1'b0;
        perr_nxt_s  = 1'b0;
        par_nxt_s   = par_r;

        case (state_r)
            ST_WAIT_IDLE: begin
                if (rxs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_nxt_s = ST_START;
                    div_nxt_s   = DIV_HALF;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (div_r != DIV_ZERO) begin
                    div_nxt_s = div_r - DIV_ONE;
                end else if (!rxs_s) begin
                    state_nxt_s = ST_DATA;
                    div_nxt_s   = DIV_FULL;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (div_r != DIV_ZERO) begin
                    div_nxt_s = div_r - DIV_ONE;
                end else begin
                    shift_nxt_s = {rxs_s, shift_r[WIDTH-1:1]};
                    div_nxt_s   = DIV_FULL;
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s = CNT_ZERO;
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (div_r != DIV_ZERO) begin
                    div_nxt_s = div_r - DIV_ONE;
                end else begin
                    par_nxt_s   = rxs_s;
                    div_nxt_s   = DIV_FULL;
                    state_nxt_s = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (div_r != DIV_ZERO) begin
                    div_nxt_s = div_r - DIV_ONE;
                end else if (!rxs_s) begin
                    // line held low through the stop bit: wait for idle before re-arming
                    ferr_nxt_s  = 1'b1;
                    state_nxt_s = ST_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
                end else if (!parity_ok(shift_r, par_r)) begin
                    perr_nxt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
`endif
                end else if (bus.full) begin
                    ovr_nxt_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    wr_nxt_s    = 1'b1;
                    data_nxt_s  = shift_r;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_IDLE;
                div_nxt_s   = DIV_ZERO;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase

        busy_nxt_s = (state_nxt_s == ST_START) || (state_nxt_s == ST_DATA) ||
                     (state_nxt_s == ST_PARITY) || (state_nxt_s == ST_STOP);
    end

    assign bus.data       = data_r;
    assign bus.wr         = wr_r;
    assign bus.busy       = busy_r;
    assign bus.frame_err  = ferr_r;
    assign bus.overrun    = ovr_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_r;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed scoreboard bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;

    uart_rx_if #(.WIDTH(8)) bif ();

    uart_rx #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .PARITY_ODD (0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int perr_cnt = 0;
    int busy_rises = 0;
    logic [7:0] exp_q[$];
    logic [3:0] prev_pulses = 4'b0000;
    logic       prev_busy   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // output monitor: pops the scoreboard on each write and polices pulse shape
    always @(negedge clk) begin
        logic [3:0] pulses;
        pulses = {bif.wr, bif.frame_err, bif.overrun, bif.parity_err};
        if (rst_n === 1'b1 && pulses != 4'b0000) begin
            check("pulse_exclusive", 32'($countones(pulses)), 32'd1);
            check("pulse_width", {28'd0, pulses & prev_pulses}, 32'd0);
            if (bif.wr) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    check("wr_data", {24'd0, bif.data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (bif.frame_err)  ferr_cnt++;
            if (bif.overrun)    ovr_cnt++;
            if (bif.parity_err) perr_cnt++;
        end
        if (bif.busy && !prev_busy) busy_rises++;
        prev_busy   = bif.busy;
        prev_pulses = pulses;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_bit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    task automatic check_counts(input string tag, input int w, input int f, input int o, input int p);
        check({tag, "_wr"},   32'(wr_cnt),   32'(w));
        check({tag, "_ferr"}, 32'(ferr_cnt), 32'(f));
        check({tag, "_ovr"},  32'(ovr_cnt),  32'(o));
        check({tag, "_perr"}, 32'(perr_cnt), 32'(p));
        check({tag, "_q"},    32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, {24'd0, bif.data}, 32'd0);
        check({tag, "_wr"},   {31'd0, bif.wr}, 32'd0);
        check({tag, "_busy"}, {31'd0, bif.busy}, 32'd0);
        check({tag, "_ferr"}, {31'd0, bif.frame_err}, 32'd0);
        check({tag, "_ovr"},  {31'd0, bif.overrun}, 32'd0);
        check({tag, "_perr"}, {31'd0, bif.parity_err}, 32'd0);
    endtask

    initial begin
        int  rises_before;
        bit  seen;
        rst_n    = 1'b0;
        rx       = 1'b1;
        bif.full = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_bits(2);

        // single byte
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        check_counts("a5", 1, 0, 0, 0);
        check("a5_data", {24'd0, bif.data}, 32'h0000_00A5);

        // back-to-back frames, one stop bit
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(2);
        check_counts("b2b", 3, 0, 0, 0);

        // short glitch on the line
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bif.busy) seen = 1'b1;
        end
        check("glitch_busy_rise", {31'd0, seen}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (!bif.busy) seen = 1'b1;
        end
        check("glitch_busy_fall", {31'd0, seen}, 32'd1);
        idle_bits(1);
        check_counts("glitch", 3, 0, 0, 0);

        // stop bit low, line held low (break)
        send_frame(8'h55, 1'b0);
        rises_before = busy_rises;
        rx = 1'b0;
        repeat (20 * CPB) @(negedge clk);
        check("break_no_rearm", 32'(busy_rises), 32'(rises_before));
        check("break_busy", {31'd0, bif.busy}, 32'd0);
        check_counts("break", 3, 1, 0, 0);
        check("break_data_hold", {24'd0, bif.data}, 32'h0000_00FF);
        idle_bits(2);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        idle_bits(2);
        check_counts("after_break", 4, 1, 0, 0);

        // overrun while FIFO full
        bif.full = 1'b1;
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        bif.full = 1'b0;
        check_counts("overrun", 4, 1, 1, 0);
        check("overrun_data_hold", {24'd0, bif.data}, 32'h0000_0012);
        exp_q.push_back(8'h3D);
        send_frame(8'h3D, 1'b1);
        idle_bits(2);
        check_counts("after_ovr", 5, 1, 1, 0);
        check("after_ovr_data", {24'd0, bif.data}, 32'h0000_003D);

        // reset in the middle of a frame
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        idle_bits(2);
        check_counts("after_rst", 6, 1, 1, 0);
        check("after_rst_data", {24'd0, bif.data}, 32'h0000_0042);

`ifdef UART_RX_PARITY_EN
        // even parity: 0x07 has odd weight, so parity bit must be 1
        send_frame_par(8'h07, 1'b0);
        idle_bits(2);
        check_counts("par_bad", 6, 1, 1, 1);
        exp_q.push_back(8'h07);
        send_frame_par(8'h07, 1'b1);
        idle_bits(2);
        check_counts("par_good", 7, 1, 1, 1);
        check("par_good_data", {24'd0, bif.data}, 32'h0000_0007);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
